// File: rtl/xf100_exu_wbck_pkg.sv
// Shared widths, state encodings and the write-back entry type for the EXU write-back arbiter.
`ifndef XF100_DEFINES_SVH
`define XF100_DEFINES_SVH
`define XF100_XLEN 32
`define XF100_RFIDX_WIDTH 5
`define XF100_WBCK_ST_NORM 1'b0
`define XF100_WBCK_ST_LP_PRI 1'b1
`define XF100_WBCK_ENTRY_W (`XF100_XLEN + `XF100_RFIDX_WIDTH)
`endif

package xf100_exu_wbck_pkg;

  localparam int unsigned XLEN    = `XF100_XLEN;
  localparam int unsigned RFIDX_W = `XF100_RFIDX_WIDTH;
  localparam int unsigned ENTRY_W = `XF100_WBCK_ENTRY_W;

  typedef enum logic {
    ST_NORM   = `XF100_WBCK_ST_NORM,
    ST_LP_PRI = `XF100_WBCK_ST_LP_PRI
  } wbck_state_e;

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    data;
  } wbck_entry_t;

  // x0 is hardwired zero: the handshake completes but nothing is written.
  function automatic logic rd_writes(input logic [RFIDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/xf100_exu_wbck_if.sv
// Handshake and register-file write-port bundle between the EXU result sources and the write-back arbiter.
interface xf100_exu_wbck_if;
  import xf100_exu_wbck_pkg::*;

  logic               alu_wbck_i_valid;
  logic               alu_wbck_i_ready;
  logic [XLEN-1:0]    alu_wbck_i_data;
  logic [RFIDX_W-1:0] alu_wbck_i_rdidx;

  logic               longp_wbck_i_valid;
  logic               longp_wbck_i_ready;
  logic [XLEN-1:0]    longp_wbck_i_data;
  logic [RFIDX_W-1:0] longp_wbck_i_rdidx;

  logic               rf_wbck_o_ena;
  logic [XLEN-1:0]    rf_wbck_o_data;
  logic [RFIDX_W-1:0] rf_wbck_o_rdidx;

  modport master (
    output alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    output longp_wbck_i_valid, longp_wbck_i_data, longp_wbck_i_rdidx,
    input  alu_wbck_i_ready, longp_wbck_i_ready,
    input  rf_wbck_o_ena, rf_wbck_o_data, rf_wbck_o_rdidx
  );

  modport slave (
    input  alu_wbck_i_valid, alu_wbck_i_data, alu_wbck_i_rdidx,
    input  longp_wbck_i_valid, longp_wbck_i_data, longp_wbck_i_rdidx,
    output alu_wbck_i_ready, longp_wbck_i_ready,
    output rf_wbck_o_ena, rf_wbck_o_data, rf_wbck_o_rdidx
  );

endinterface

// File: rtl/xf100_wbck_fifo.sv
// Small synchronous FIFO buffering long-pipe write-back entries; only built with XF100_WBCK_LONGP_FIFO_EN.
`ifdef XF100_WBCK_LONGP_FIFO_EN
module xf100_wbck_fifo
  import xf100_exu_wbck_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enq_i,
  input  wbck_entry_t enq_data_i,
  input  logic        deq_i,
  output logic        full_o,
  output logic        empty_o,
  output wbck_entry_t head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  wbck_entry_t   mem_q [DEPTH];
  wbck_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_enq, do_deq;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Full blocks enqueue even if the head leaves this cycle: no pass-through.
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    do_enq = enq_i && !full_o;
    do_deq = deq_i && !empty_o;
    if (do_enq) begin
      mem_d[wr_q] = enq_data_i;
      wr_d        = (wr_q == LAST) ? '0 : wr_q + AW'(1);
    end
    if (do_deq) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
    end
    case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`endif

// File: rtl/xf100_exu_wbck.sv
// EXU write-back arbiter: ALU-priority grant with a long-pipe starvation guard, registered rf write port.
// Define XF100_WBCK_LONGP_FIFO_EN to buffer the long pipe in a LONGP_FIFO_DEPTH-entry FIFO.
module xf100_exu_wbck
  import xf100_exu_wbck_pkg::*;
#(
  parameter int unsigned STARVE_MAX       = 4,
  parameter int unsigned LONGP_FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  xf100_exu_wbck_if.slave  wbck
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  wbck_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rf_ena_q, rf_ena_d;
  logic [XLEN-1:0]    rf_data_q, rf_data_d;
  logic [RFIDX_W-1:0] rf_rdidx_q, rf_rdidx_d;

  logic               lp_vld;
  wbck_entry_t        lp_head, lp_in;
  logic [ENTRY_W-1:0] lp_in_flat;
  logic               alu_gnt_c, lp_gnt_c;

  assign lp_in_flat = {wbck.longp_wbck_i_rdidx, wbck.longp_wbck_i_data};
  assign lp_in      = wbck_entry_t'(lp_in_flat);

`ifdef XF100_WBCK_LONGP_FIFO_EN
  logic fifo_full, fifo_empty;

  xf100_wbck_fifo #(.DEPTH(LONGP_FIFO_DEPTH)) u_longp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (wbck.longp_wbck_i_valid),
    .enq_data_i (lp_in),
    .deq_i      (lp_gnt_c),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (lp_head)
  );

  assign lp_vld                  = !fifo_empty;
  assign wbck.longp_wbck_i_ready = !fifo_full;
`else
  logic unused_fifo_depth;
  assign unused_fifo_depth = ^LONGP_FIFO_DEPTH;

  assign lp_vld                  = wbck.longp_wbck_i_valid;
  assign lp_head                 = lp_in;
  assign wbck.longp_wbck_i_ready = (state_q == ST_LP_PRI) || !wbck.alu_wbck_i_valid;
`endif

  assign wbck.alu_wbck_i_ready = (state_q == ST_NORM);
  assign wbck.rf_wbck_o_ena    = rf_ena_q;
  assign wbck.rf_wbck_o_data   = rf_data_q;
  assign wbck.rf_wbck_o_rdidx  = rf_rdidx_q;

  // Arbitration, starvation tracking and write-back capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_gnt_c  = 1'b0;
    lp_gnt_c   = 1'b0;
    rf_ena_d   = 1'b0;
    rf_data_d  = rf_data_q;
    rf_rdidx_d = rf_rdidx_q;
    case (state_q)
      ST_NORM: begin
        if (wbck.alu_wbck_i_valid) begin
          alu_gnt_c = 1'b1;
          if (lp_vld) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) state_d = ST_LP_PRI;
          end
        end else if (lp_vld) begin
          lp_gnt_c = 1'b1;
        end
      end
      ST_LP_PRI: begin
        lp_gnt_c = lp_vld;
        state_d  = ST_NORM;
      end
      default: state_d = ST_NORM;
    endcase
    if (lp_gnt_c) cnt_d = '0;
    if (alu_gnt_c) begin
      rf_ena_d   = rd_writes(wbck.alu_wbck_i_rdidx);
      rf_data_d  = wbck.alu_wbck_i_data;
      rf_rdidx_d = wbck.alu_wbck_i_rdidx;
    end else if (lp_gnt_c) begin
      rf_ena_d   = rd_writes(lp_head.rdidx);
      rf_data_d  = lp_head.data;
      rf_rdidx_d = lp_head.rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_NORM;
      cnt_q      <= '0;
      rf_ena_q   <= 1'b0;
      rf_data_q  <= '0;
      rf_rdidx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_ena_q   <= rf_ena_d;
      rf_data_q  <= rf_data_d;
      rf_rdidx_q <= rf_rdidx_d;
    end
  end

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// Directed self-checking bench for xf100_exu_wbck (STARVE_MAX=4, LONGP_FIFO_DEPTH=2).
module tb_xf100_exu_wbck;
  import xf100_exu_wbck_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  xf100_exu_wbck_if wif();

  xf100_exu_wbck #(.STARVE_MAX(4), .LONGP_FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wbck  (wif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    wif.alu_wbck_i_valid   = 1'b0;
    wif.alu_wbck_i_data    = '0;
    wif.alu_wbck_i_rdidx   = '0;
    wif.longp_wbck_i_valid = 1'b0;
    wif.longp_wbck_i_data  = '0;
    wif.longp_wbck_i_rdidx = '0;
  endtask

  task automatic alu(input logic v, input logic [RFIDX_W-1:0] idx, input logic [XLEN-1:0] d);
    wif.alu_wbck_i_valid = v;
    wif.alu_wbck_i_rdidx = idx;
    wif.alu_wbck_i_data  = d;
  endtask

  task automatic lp(input logic v, input logic [RFIDX_W-1:0] idx, input logic [XLEN-1:0] d);
    wif.longp_wbck_i_valid = v;
    wif.longp_wbck_i_rdidx = idx;
    wif.longp_wbck_i_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] adat;
`ifdef XF100_WBCK_LONGP_FIFO_EN
    int   pushed;
    int   drop_at;
    int   stray;
    logic [63:0] seen[$];
`endif
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    smp();
    chk("rst_ena",     64'(wif.rf_wbck_o_ena), 0);
    chk("rst_data",    64'(wif.rf_wbck_o_data), 0);
    chk("rst_rdidx",   64'(wif.rf_wbck_o_rdidx), 0);
    chk("rst_alu_rdy", 64'(wif.alu_wbck_i_ready), 1);
    chk("rst_lp_rdy",  64'(wif.longp_wbck_i_ready), 1);

    // Single ALU write, 1-cycle latency, one-cycle enable pulse
    step(); alu(1'b1, 5'd5, 32'h1234_5678);
    smp();  chk("alu_rdy", 64'(wif.alu_wbck_i_ready), 1);
    step(); idle();
    smp();
    chk("alu_ena",   64'(wif.rf_wbck_o_ena), 1);
    chk("alu_rdidx", 64'(wif.rf_wbck_o_rdidx), 5);
    chk("alu_data",  64'(wif.rf_wbck_o_data), 64'h1234_5678);
    step(); smp();
    chk("alu_ena_pulse", 64'(wif.rf_wbck_o_ena), 0);
    chk("alu_data_hold", 64'(wif.rf_wbck_o_data), 64'h1234_5678);

    // x0 write: handshake completes, no rf enable, data/index still load
    step(); alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    smp();  chk("x0_rdy", 64'(wif.alu_wbck_i_ready), 1);
    step(); idle();
    smp();
    chk("x0_ena",   64'(wif.rf_wbck_o_ena), 0);
    chk("x0_data",  64'(wif.rf_wbck_o_data), 64'hDEAD_BEEF);
    chk("x0_rdidx", 64'(wif.rf_wbck_o_rdidx), 0);

`ifndef XF100_WBCK_LONGP_FIFO_EN
    // Starvation: ALU saturating, long pipe forced in at cycle 4
    adat = 32'h100;
    step(); alu(1'b1, 5'd3, adat); lp(1'b1, 5'd7, 32'hA5);
    for (int c = 0; c < 7; c++) begin
      smp();
      if (c >= 1) begin
        chk("stv_ena", 64'(wif.rf_wbck_o_ena), 1);
        if (c == 5) begin
          chk("stv_lp_rdidx", 64'(wif.rf_wbck_o_rdidx), 7);
          chk("stv_lp_data",  64'(wif.rf_wbck_o_data), 64'hA5);
        end else begin
          chk("stv_alu_rdidx", 64'(wif.rf_wbck_o_rdidx), 3);
          chk("stv_alu_data",  64'(wif.rf_wbck_o_data),
              (c < 5) ? 64'(32'h100 + 32'(c - 1)) : 64'h104);
        end
      end
      if (c < 6) begin
        chk("stv_alu_rdy", 64'(wif.alu_wbck_i_ready), (c != 4) ? 64'd1 : 64'd0);
        chk("stv_lp_rdy",  64'(wif.longp_wbck_i_ready), (c == 4) ? 64'd1 : 64'd0);
      end
      step();
      if (c == 4) wif.longp_wbck_i_valid = 1'b0;
      if (c != 4) adat = adat + 32'd1;
      wif.alu_wbck_i_data = adat;
      if (c == 5) wif.alu_wbck_i_valid = 1'b0;
    end

    // Long pipe alone, back-to-back
    for (int i = 0; i < 5; i++) begin
      if (i < 4) lp(1'b1, 5'(10 + i), 32'h200 + 32'(i));
      else       lp(1'b0, 5'd0, 32'd0);
      smp();
      if (i < 4) chk("lpa_rdy", 64'(wif.longp_wbck_i_ready), 1);
      if (i >= 1) begin
        chk("lpa_ena",   64'(wif.rf_wbck_o_ena), 1);
        chk("lpa_rdidx", 64'(wif.rf_wbck_o_rdidx), 64'(10 + i - 1));
        chk("lpa_data",  64'(wif.rf_wbck_o_data), 64'(32'h200 + 32'(i - 1)));
      end
      step();
    end
    smp(); chk("lpa_end_ena", 64'(wif.rf_wbck_o_ena), 0);

    // Build the counter to 3, then reset and confirm a full fresh window
    step(); alu(1'b1, 5'd3, 32'h300); lp(1'b1, 5'd9, 32'h99);
    for (int c = 0; c < 3; c++) begin
      smp(); chk("rsb_alu_rdy", 64'(wif.alu_wbck_i_ready), 1);
      step();
    end
    rst_n = 1'b0; idle();
    step(); rst_n = 1'b1;
    smp();
    chk("rs_ena",     64'(wif.rf_wbck_o_ena), 0);
    chk("rs_data",    64'(wif.rf_wbck_o_data), 0);
    chk("rs_rdidx",   64'(wif.rf_wbck_o_rdidx), 0);
    chk("rs_alu_rdy", 64'(wif.alu_wbck_i_ready), 1);
    chk("rs_lp_rdy",  64'(wif.longp_wbck_i_ready), 1);
    step(); alu(1'b1, 5'd3, 32'h300); lp(1'b1, 5'd9, 32'h99);
    for (int c = 0; c < 5; c++) begin
      smp(); chk("rsa_alu_rdy", 64'(wif.alu_wbck_i_ready), (c != 4) ? 64'd1 : 64'd0);
      step();
      if (c == 4) wif.longp_wbck_i_valid = 1'b0;
    end
    idle();
    smp();
    chk("rsa_lp_rdidx", 64'(wif.rf_wbck_o_rdidx), 9);
    chk("rsa_lp_data",  64'(wif.rf_wbck_o_data), 64'h99);
    step();
`else
    // FIFO: three pushes against a saturating ALU, in-order drain
    pushed  = 0;
    drop_at = -1;
    step(); alu(1'b1, 5'd3, 32'h400);
    for (int c = 0; c < 40; c++) begin
      if (c == 30) wif.alu_wbck_i_valid = 1'b0;
      lp(pushed < 3, 5'(7 + pushed), 32'hA0 + 32'(pushed));
      smp();
      if (wif.rf_wbck_o_ena && wif.rf_wbck_o_rdidx >= 5'd7 && wif.rf_wbck_o_rdidx <= 5'd9)
        seen.push_back({27'd0, wif.rf_wbck_o_rdidx, wif.rf_wbck_o_data});
      if (wif.longp_wbck_i_valid && !wif.longp_wbck_i_ready && drop_at < 0) drop_at = pushed;
      if (wif.longp_wbck_i_valid && wif.longp_wbck_i_ready) pushed++;
      step();
    end
    idle();
    chk("fifo_drop_after", 64'(drop_at), 2);
    chk("fifo_pushed",     64'(pushed), 3);
    chk("fifo_nwrites",    64'(seen.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size())
        chk("fifo_order", seen[i], {27'd0, 5'(7 + i), 32'hA0 + 32'(i)});
    end

    // FIFO holding two entries with counter at 3, then reset discards them
    step(); alu(1'b1, 5'd3, 32'h500);
    for (int c = 0; c < 4; c++) begin
      lp(c < 2, 5'(11 + c), 32'hB0 + 32'(c));
      smp();
      if (c < 2) chk("frs_push_rdy", 64'(wif.longp_wbck_i_ready), 1);
      step();
    end
    rst_n = 1'b0; idle();
    step(); rst_n = 1'b1;
    smp();
    chk("frs_ena",     64'(wif.rf_wbck_o_ena), 0);
    chk("frs_data",    64'(wif.rf_wbck_o_data), 0);
    chk("frs_rdidx",   64'(wif.rf_wbck_o_rdidx), 0);
    chk("frs_alu_rdy", 64'(wif.alu_wbck_i_ready), 1);
    chk("frs_lp_rdy",  64'(wif.longp_wbck_i_ready), 1);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      step(); smp();
      if (wif.rf_wbck_o_ena) stray++;
    end
    chk("frs_no_stale_writes", 64'(stray), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
